ctrl_fsm_layer: RTL and testbench

- Layer-level control FSM that sits directly upstream of the conv-volume counter (ctrl_cnt_in_vol) and drives its `cnt_load`, `cnt_in_vol` and `cnt_clear_vol` inputs.
- Consumes the counter's `op_done` to decide, at FINISH, whether to start another conv volume or return to IDLE.
- Per volume it sequences operand fetch, MAC accumulation, pipeline drain and result hand-off to the writeback stage.

---
 rtl/ctrl_fsm_layer.sv | 198 +++++++++++++++++++
 tb/tb_ctrl_fsm_layer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm_layer.sv
// Layer-level control FSM: sequences fetch, MAC, drain and writeback per conv volume and drives the volume counter.
// Optional abort input is compiled in when CTRL_FSM_ABORT_EN is defined.
module ctrl_fsm_layer #(
    parameter int MNV      = 224*224,
    parameter int MAX_K    = 3*3*512,
    parameter int PIPE_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(MNV)-1:0]     cfg_num_vol,
    input  logic [$clog2(MAX_K+1)-1:0] cfg_mac_len,
    output logic                       busy,
    output logic                       op_rd_req,
    input  logic                       op_rd_gnt,
    output logic [$clog2(MAX_K+1)-1:0] op_rd_idx,
    output logic                       acc_clear,
    output logic                       acc_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       cnt_load,
    output logic [$clog2(MNV)-1:0]     cnt_max_val,
    output logic                       cnt_in_vol,
    output logic                       cnt_clear_vol,
    input  logic                       op_done,
`ifdef CTRL_FSM_ABORT_EN
    input  logic                       abort,
`endif
    output logic                       layer_done
);

    localparam int NW = $clog2(MNV);
    localparam int KW = $clog2(MAX_K+1);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_FETCH,
        S_DRAIN,
        S_STORE,
        S_NEXT,
        S_SETTLE,
        S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] mac_len_q, mac_len_d;
    logic [NW-1:0] num_vol_q, num_vol_d;
    logic [KW-1:0] idx_q, idx_d;
    logic [DW-1:0] drain_q, drain_d;

    logic busy_q, busy_d;
    logic op_rd_req_q, op_rd_req_d;
    logic acc_clear_q, acc_clear_d;
    logic acc_en_q, acc_en_d;
    logic out_valid_q, out_valid_d;
    logic cnt_load_q, cnt_load_d;
    logic cnt_in_vol_q, cnt_in_vol_d;
    logic cnt_clear_vol_q, cnt_clear_vol_d;
    logic layer_done_q, layer_done_d;
    logic clear_req;

    always_comb begin
        state_d      = state_q;
        mac_len_d    = mac_len_q;
        num_vol_d    = num_vol_q;
        idx_d        = idx_q;
        drain_d      = drain_q;
        acc_en_d     = 1'b0;
        layer_done_d = 1'b0;
        clear_req    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_num_vol != '0) begin
                        num_vol_d = cfg_num_vol;
                        mac_len_d = (cfg_mac_len == '0) ? KW'(1) : cfg_mac_len;
                        state_d   = S_CLEAR;
                    end else begin
                        layer_done_d = 1'b1;
                    end
                end
            end
            S_CLEAR: state_d = S_LOAD;
            S_LOAD: begin
                idx_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (op_rd_gnt) begin
                    acc_en_d = 1'b1;
                    if (idx_q == mac_len_q - KW'(1)) begin
                        idx_d   = '0;
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + KW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(PIPE_LAT-1)) begin
                    state_d = S_STORE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            // out_valid is already high here, so the handshake completes on this edge
            S_STORE: begin
                if (out_ready) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_FINISH;
            S_FINISH: begin
                idx_d = '0;
                if (op_done) begin
                    layer_done_d = 1'b1;
                    clear_req    = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CTRL_FSM_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            acc_en_d     = 1'b0;
            layer_done_d = 1'b0;
            clear_req    = 1'b1;
        end
`endif

        // Outputs are registered from the next state so they line up with the state they describe
        busy_d          = (state_d != S_IDLE);
        op_rd_req_d     = (state_d == S_FETCH);
        acc_clear_d     = (state_d == S_FETCH) && (state_q != S_FETCH);
        out_valid_d     = (state_d == S_STORE);
        cnt_load_d      = (state_d == S_LOAD);
        cnt_in_vol_d    = (state_d == S_NEXT);
        cnt_clear_vol_d = (state_d == S_CLEAR) || clear_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            mac_len_q       <= '0;
            num_vol_q       <= '0;
            idx_q           <= '0;
            drain_q         <= '0;
            busy_q          <= 1'b0;
            op_rd_req_q     <= 1'b0;
            acc_clear_q     <= 1'b0;
            acc_en_q        <= 1'b0;
            out_valid_q     <= 1'b0;
            cnt_load_q      <= 1'b0;
            cnt_in_vol_q    <= 1'b0;
            cnt_clear_vol_q <= 1'b0;
            layer_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            mac_len_q       <= mac_len_d;
            num_vol_q       <= num_vol_d;
            idx_q           <= idx_d;
            drain_q         <= drain_d;
            busy_q          <= busy_d;
            op_rd_req_q     <= op_rd_req_d;
            acc_clear_q     <= acc_clear_d;
            acc_en_q        <= acc_en_d;
            out_valid_q     <= out_valid_d;
            cnt_load_q      <= cnt_load_d;
            cnt_in_vol_q    <= cnt_in_vol_d;
            cnt_clear_vol_q <= cnt_clear_vol_d;
            layer_done_q    <= layer_done_d;
        end
    end

    assign busy          = busy_q;
    assign op_rd_req     = op_rd_req_q;
    assign op_rd_idx     = idx_q;
    assign acc_clear     = acc_clear_q;
    assign acc_en        = acc_en_q;
    assign out_valid     = out_valid_q;
    assign cnt_load      = cnt_load_q;
    assign cnt_max_val   = num_vol_q;
    assign cnt_in_vol    = cnt_in_vol_q;
    assign cnt_clear_vol = cnt_clear_vol_q;
    assign layer_done    = layer_done_q;

endmodule

// File: tb/tb_ctrl_fsm_layer.sv
// Scoreboard bench for ctrl_fsm_layer with a behavioural volume counter attached to cnt_* / op_done.
// Define CTRL_FSM_ABORT_EN for both files to include the abort scenario.
module tb_ctrl_fsm_layer;

    localparam int MNV      = 224*224;
    localparam int MAX_K    = 3*3*512;
    localparam int PIPE_LAT = 4;
    localparam int NW       = $clog2(MNV);
    localparam int KW       = $clog2(MAX_K+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NW-1:0] cfg_num_vol;
    logic [KW-1:0] cfg_mac_len;
    logic          busy;
    logic          op_rd_req;
    logic          op_rd_gnt;
    logic [KW-1:0] op_rd_idx;
    logic          acc_clear;
    logic          acc_en;
    logic          out_valid;
    logic          out_ready;
    logic          cnt_load;
    logic [NW-1:0] cnt_max_val;
    logic          cnt_in_vol;
    logic          cnt_clear_vol;
    logic          op_done;
    logic          layer_done;
`ifdef CTRL_FSM_ABORT_EN
    logic          abort;
`endif

    always #5 clk = ~clk;

    ctrl_fsm_layer #(.MNV(MNV), .MAX_K(MAX_K), .PIPE_LAT(PIPE_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_num_vol   (cfg_num_vol),
        .cfg_mac_len   (cfg_mac_len),
        .busy          (busy),
        .op_rd_req     (op_rd_req),
        .op_rd_gnt     (op_rd_gnt),
        .op_rd_idx     (op_rd_idx),
        .acc_clear     (acc_clear),
        .acc_en        (acc_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .cnt_load      (cnt_load),
        .cnt_max_val   (cnt_max_val),
        .cnt_in_vol    (cnt_in_vol),
        .cnt_clear_vol (cnt_clear_vol),
        .op_done       (op_done),
`ifdef CTRL_FSM_ABORT_EN
        .abort         (abort),
`endif
        .layer_done    (layer_done)
    );

    // Volume counter model: registered op_done once the count reaches the loaded maximum
    logic [NW-1:0] m_cnt, m_max;
    always @(posedge clk) begin
        if (rst) begin
            m_cnt   <= '0;
            m_max   <= '0;
            op_done <= 1'b0;
        end else begin
            if (cnt_clear_vol)   m_cnt <= '0;
            else if (cnt_in_vol) m_cnt <= m_cnt + NW'(1);
            if (cnt_load)        m_max <= cnt_max_val;
            op_done <= (m_max != '0) && (m_cnt == m_max);
        end
    end

    typedef struct {
        int vol;
        int acc;
    } exp_t;

    exp_t sb_q[$];
    int   ld_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int cyc, n_acc, n_xfer, n_in_vol, n_load, n_ld, n_clr;
    int gap_min, gap_max, last_iv, ov_run, max_ov;
    int stall_idx_cnt, proto_err, sb_extra, acc_cnt, vol_obs, mac_eff;
    int stall_k, stall_left, hold_left;
    bit prev_gnt, prev_xfer, prev_hold, prev_rst;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] outs_now();
        return {busy, op_rd_req, op_rd_idx, acc_clear, acc_en, out_valid,
                cnt_load, cnt_max_val, cnt_in_vol, cnt_clear_vol, layer_done};
    endfunction

    task automatic clear_stats();
        n_acc = 0; n_xfer = 0; n_in_vol = 0; n_load = 0; n_ld = 0; n_clr = 0;
        gap_min = 1000000; gap_max = 0; last_iv = -1; ov_run = 0; max_ov = 0;
        stall_idx_cnt = 0; proto_err = 0; sb_extra = 0;
    endtask

    task automatic sample();
        exp_t e;
        cyc++;
        if (!prev_rst) begin
            if (acc_en !== prev_gnt)                     proto_err++;
            if (cnt_in_vol && !prev_xfer)                proto_err++;
            if (prev_hold && !out_valid)                 proto_err++;
            if (op_rd_req && int'(op_rd_idx) >= mac_eff) proto_err++;
        end
        if (op_rd_req && !op_rd_gnt && op_rd_idx == KW'(2)) stall_idx_cnt++;
        if (acc_clear) acc_cnt = 0;
        if (acc_en) begin
            acc_cnt++;
            n_acc++;
        end
        if (cnt_clear_vol) n_clr++;
        if (cnt_load) begin
            n_load++;
            vol_obs = 0;
        end
        if (cnt_in_vol) begin
            n_in_vol++;
            if (last_iv >= 0) begin
                if (cyc - last_iv < gap_min) gap_min = cyc - last_iv;
                if (cyc - last_iv > gap_max) gap_max = cyc - last_iv;
            end
            last_iv = cyc;
        end
        if (out_valid) ov_run++;
        else           ov_run = 0;
        if (ov_run > max_ov) max_ov = ov_run;
        if (out_valid && out_ready) begin
            n_xfer++;
            if (sb_q.size() == 0) begin
                sb_extra++;
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_vol", longint'(vol_obs), longint'(e.vol));
                check_eq("sb_acc", longint'(acc_cnt), longint'(e.acc));
            end
            vol_obs++;
        end
        if (layer_done) begin
            n_ld++;
            if (ld_q.size() == 0) sb_extra++;
            else                  void'(ld_q.pop_front());
        end
        prev_gnt  = op_rd_req && op_rd_gnt;
        prev_xfer = out_valid && out_ready;
        prev_hold = out_valid && !out_ready;
        prev_rst  = rst;
    endtask

    task automatic drive_auto();
        if (op_rd_req && op_rd_idx == KW'(stall_k) && stall_left > 0) begin
            op_rd_gnt = 1'b0;
            stall_left--;
        end else begin
            op_rd_gnt = 1'b1;
        end
        if (out_valid && hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive_auto();
    endtask

    task automatic start_layer(input int num, input int mac);
        exp_t e;
        cfg_num_vol = NW'(num);
        cfg_mac_len = KW'(mac);
        mac_eff     = (mac == 0) ? 1 : mac;
        for (int v = 0; v < num; v++) begin
            e.vol = v;
            e.acc = mac_eff;
            sb_q.push_back(e);
        end
        ld_q.push_back(1);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_layer(input string tag, input int budget);
        int base;
        int n;
        base = n_ld;
        n    = 0;
        while (n_ld == base && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_timeout"}, longint'(n_ld == base), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; cfg_num_vol = '0; cfg_mac_len = '0;
        op_rd_gnt = 1'b1; out_ready = 1'b1;
`ifdef CTRL_FSM_ABORT_EN
        abort = 1'b0;
`endif
        cyc = 0; acc_cnt = 0; vol_obs = 0; mac_eff = 1;
        stall_k = 0; stall_left = 0; hold_left = 0;
        prev_gnt = 1'b0; prev_xfer = 1'b0; prev_hold = 1'b0; prev_rst = 1'b1;
        clear_stats();
        repeat (3) step();
        check_eq("reset_outs", longint'(outs_now()), 0);
        rst = 1'b0;
        step();

        // Basic layer: 3 volumes of 4 MAC steps, no stalls
        clear_stats();
        start_layer(3, 4);
        wait_layer("basic", 200);
        check_eq("basic_acc_en", longint'(n_acc), 12);
        check_eq("basic_xfer", longint'(n_xfer), 3);
        check_eq("basic_in_vol", longint'(n_in_vol), 3);
        check_eq("basic_load", longint'(n_load), 1);
        check_eq("basic_clear_vol", longint'(n_clr), 2);
        check_eq("basic_period_min", longint'(gap_min), 12);
        check_eq("basic_period_max", longint'(gap_max), 12);
        check_eq("basic_max_val", longint'(cnt_max_val), 3);
        step();
        check_eq("basic_ld_pulse", longint'(layer_done), 0);
        check_eq("basic_ld_count", longint'(n_ld), 1);
        check_eq("basic_proto", longint'(proto_err), 0);
        check_eq("basic_sb_left", longint'(sb_q.size() + ld_q.size() + sb_extra), 0);

        // Fetch stall of 5 cycles at k=2
        clear_stats();
        stall_k = 2; stall_left = 5;
        start_layer(2, 4);
        wait_layer("stall", 200);
        check_eq("stall_idx_held", longint'(stall_idx_cnt), 5);
        check_eq("stall_acc_en", longint'(n_acc), 8);
        check_eq("stall_xfer", longint'(n_xfer), 2);
        check_eq("stall_proto", longint'(proto_err), 0);
        check_eq("stall_sb_left", longint'(sb_q.size() + ld_q.size() + sb_extra), 0);

        // Writeback backpressure of 7 cycles
        clear_stats();
        hold_left = 7;
        start_layer(2, 2);
        wait_layer("bp", 200);
        check_eq("bp_valid_len", longint'(max_ov), 8);
        check_eq("bp_xfer", longint'(n_xfer), 2);
        check_eq("bp_in_vol", longint'(n_in_vol), 2);
        check_eq("bp_proto", longint'(proto_err), 0);
        check_eq("bp_sb_left", longint'(sb_q.size() + ld_q.size() + sb_extra), 0);

        // Zero volumes: immediate layer_done, counter untouched
        clear_stats();
        cfg_num_vol = '0;
        cfg_mac_len = KW'(4);
        ld_q.push_back(1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("nv0_layer_done", longint'(layer_done), 1);
        check_eq("nv0_busy", longint'(busy), 0);
        repeat (5) step();
        check_eq("nv0_load", longint'(n_load), 0);
        check_eq("nv0_clear_vol", longint'(n_clr), 0);
        check_eq("nv0_busy_after", longint'(busy), 0);
        check_eq("nv0_ld_count", longint'(n_ld), 1);

        // Zero MAC length behaves as one step
        clear_stats();
        start_layer(2, 0);
        wait_layer("ml0", 200);
        check_eq("ml0_acc_en", longint'(n_acc), 2);
        check_eq("ml0_xfer", longint'(n_xfer), 2);
        check_eq("ml0_proto", longint'(proto_err), 0);
        check_eq("ml0_sb_left", longint'(sb_q.size() + ld_q.size() + sb_extra), 0);

        // Start pulsed while fetching is ignored
        clear_stats();
        start_layer(2, 4);
        n = 0;
        while (!op_rd_req && n < 50) begin
            step();
            n++;
        end
        check_eq("sib_reach_fetch", longint'(op_rd_req), 1);
        cfg_num_vol = NW'(5);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_layer("sib", 200);
        repeat (20) step();
        check_eq("sib_max_val", longint'(cnt_max_val), 2);
        check_eq("sib_xfer", longint'(n_xfer), 2);
        check_eq("sib_load", longint'(n_load), 1);
        check_eq("sib_busy_after", longint'(busy), 0);
        check_eq("sib_sb_left", longint'(sb_q.size() + ld_q.size() + sb_extra), 0);

        // Reset while held in STORE, then a fresh layer
        clear_stats();
        hold_left = 10;
        start_layer(3, 2);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check_eq("rst_reach_store", longint'(out_valid), 1);
        rst = 1'b1;
        step();
        check_eq("rst_outs", longint'(outs_now()), 0);
        rst = 1'b0;
        hold_left = 0;
        sb_q.delete();
        ld_q.delete();
        step();
        clear_stats();
        start_layer(2, 3);
        wait_layer("rst_fresh", 200);
        check_eq("rst_fresh_xfer", longint'(n_xfer), 2);
        check_eq("rst_fresh_acc_en", longint'(n_acc), 6);
        check_eq("rst_fresh_proto", longint'(proto_err), 0);
        check_eq("rst_fresh_sb_left", longint'(sb_q.size() + ld_q.size() + sb_extra), 0);

`ifdef CTRL_FSM_ABORT_EN
        // Abort in DRAIN of volume 2 of 5
        clear_stats();
        start_layer(5, 2);
        n = 0;
        while (!(n_in_vol == 1 && acc_en && !op_rd_req) && n < 200) begin
            step();
            n++;
        end
        check_eq("abort_reach_drain", longint'(n_in_vol == 1 && acc_en && !op_rd_req), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_clear_vol", longint'(cnt_clear_vol), 1);
        check_eq("abort_busy", longint'(busy), 0);
        check_eq("abort_layer_done", longint'(layer_done), 0);
        check_eq("abort_req_valid", longint'({op_rd_req, out_valid}), 0);
        sb_q.delete();
        ld_q.delete();
        repeat (10) step();
        check_eq("abort_no_ld", longint'(n_ld), 0);
        check_eq("abort_idle", longint'(busy), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
